// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding request/response port to AXI4-Lite master bridge.
// Optional abort of stalled AXI waits: define AXI4L_TIMEOUT_EN.
module axi4_lite_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK_i,
    input  logic                  ARESETN_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_wstrb_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [31:0]           resp_rdata_o,
    output logic [1:0]            resp_resp_o,
    output logic                  resp_err_o,
    output logic                  resp_timeout_o,
    output logic [31:0]           ARADDR_o,
    output logic                  ARVALID_o,
    input  logic                  ARREADY_i,
    input  logic [31:0]           RDATA_i,
    input  logic [1:0]            RRESP_i,
    input  logic                  RVALID_i,
    output logic                  RREADY_o,
    output logic [31:0]           AWADDR_o,
    output logic                  AWVALID_o,
    input  logic                  AWREADY_i,
    output logic [31:0]           WDATA_o,
    output logic [3:0]            WSTRB_o,
    output logic                  WVALID_o,
    input  logic                  WREADY_i,
    input  logic [1:0]            BRESP_i,
    input  logic                  BVALID_i,
    output logic                  BREADY_o,
    output logic [2:0]            dbg_state_o
);
    // Handshake rule on every channel: a transfer happens on the rising edge where
    // VALID and READY are both high; VALID, once raised, holds until that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RESP    = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [1:0]  resp_resp_q, resp_resp_d;
    logic        aw_done_n, w_done_n;

    // TIMEOUT_CYCLES below 1 is not a supported configuration.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unsupported
    end

`ifdef AXI4L_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        resp_timeout_q, resp_timeout_d;
`endif

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        resp_resp_d  = resp_resp_q;
        aw_done_n    = aw_done_q | (awvalid_q & AWREADY_i);
        w_done_n     = w_done_q | (wvalid_q & WREADY_i);
`ifdef AXI4L_TIMEOUT_EN
        cnt_d          = cnt_q;
        resp_timeout_d = resp_timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (req_write_i) begin
                        awaddr_d  = 32'(req_addr_i);
                        wdata_d   = req_wdata_i;
                        wstrb_d   = req_wstrb_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = 32'(req_addr_i);
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (ARREADY_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RVALID_i) begin
                    rready_d     = 1'b0;
                    resp_rdata_d = RDATA_i;
                    resp_resp_d  = RRESP_i;
                    resp_err_d   = RRESP_i[1];
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
`ifdef AXI4L_TIMEOUT_EN
                    resp_timeout_d = 1'b0;
`endif
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each VALID drops after its own transfer.
                awvalid_d = awvalid_q & ~AWREADY_i;
                wvalid_d  = wvalid_q & ~WREADY_i;
                aw_done_d = aw_done_n;
                w_done_d  = w_done_n;
                if (aw_done_n && w_done_n) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID_i) begin
                    bready_d     = 1'b0;
                    resp_rdata_d = 32'h0;
                    resp_resp_d  = BRESP_i;
                    resp_err_d   = BRESP_i[1];
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
`ifdef AXI4L_TIMEOUT_EN
                    resp_timeout_d = 1'b0;
`endif
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI4L_TIMEOUT_EN
        // The counter restarts on every state change, so partial AW/W progress does not extend it.
        if (state_d != state_q) begin
            cnt_d = 32'h0;
        end else if (state_q == RD_ADDR || state_q == RD_DATA ||
                     state_q == WR_REQ || state_q == WR_RESP) begin
            if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                arvalid_d      = 1'b0;
                rready_d       = 1'b0;
                awvalid_d      = 1'b0;
                wvalid_d       = 1'b0;
                bready_d       = 1'b0;
                resp_rdata_d   = 32'h0;
                resp_resp_d    = 2'b10;
                resp_err_d     = 1'b1;
                resp_timeout_d = 1'b1;
                resp_valid_d   = 1'b1;
                state_d        = RESP;
                cnt_d          = 32'h0;
            end else begin
                cnt_d = cnt_q + 32'h1;
            end
        end
`endif
    end

    always_ff @(posedge ACLK_i or negedge ARESETN_i) begin
        if (!ARESETN_i) begin
            state_q      <= IDLE;
            araddr_q     <= 32'h0;
            awaddr_q     <= 32'h0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_resp_q  <= 2'b00;
`ifdef AXI4L_TIMEOUT_EN
            cnt_q          <= 32'h0;
            resp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            resp_resp_q  <= resp_resp_d;
`ifdef AXI4L_TIMEOUT_EN
            cnt_q          <= cnt_d;
            resp_timeout_q <= resp_timeout_d;
`endif
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign dbg_state_o  = state_q;
    assign ARADDR_o     = araddr_q;
    assign ARVALID_o    = arvalid_q;
    assign RREADY_o     = rready_q;
    assign AWADDR_o     = awaddr_q;
    assign AWVALID_o    = awvalid_q;
    assign WDATA_o      = wdata_q;
    assign WSTRB_o      = wstrb_q;
    assign WVALID_o     = wvalid_q;
    assign BREADY_o     = bready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_resp_o  = resp_resp_q;
`ifdef AXI4L_TIMEOUT_EN
    assign resp_err_o     = resp_err_q | resp_timeout_q;
    assign resp_timeout_o = resp_timeout_q;
`else
    assign resp_err_o     = resp_err_q;
    assign resp_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench for axi4_lite_master_bridge: vector table run against a delay-programmable AXI slave model.
module tb_axi4_lite_master_bridge;
    logic        ACLK_i = 1'b0;
    logic        ARESETN_i;
    logic        req_valid_i, req_ready_o, req_write_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o, resp_timeout_o;
    logic [31:0] resp_rdata_o;
    logic [1:0]  resp_resp_o;
    logic [31:0] ARADDR_o, RDATA_i, AWADDR_o, WDATA_o;
    logic        ARVALID_o, ARREADY_i, RVALID_i, RREADY_o;
    logic        AWVALID_o, AWREADY_i, WVALID_o, WREADY_i, BVALID_i, BREADY_o;
    logic [1:0]  RRESP_i, BRESP_i;
    logic [3:0]  WSTRB_o;
    logic [2:0]  dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          a_dly;     // cycles ARVALID/AWVALID waits before READY
        int          w_dly;     // cycles WVALID waits before WREADY
        int          d_dly;     // cycles RREADY/BREADY waits before RVALID/BVALID
        int          hold;      // cycles resp_ready_i stays low once resp_valid_o seen
        logic [31:0] sdata;
        logic [1:0]  sresp;
        int          exp_lat;
        int          exp_a_hi;
        int          exp_w_hi;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        bit          exp_err;
        bit          exp_to;
    } vec_t;

    vec_t vecs[7];

    axi4_lite_master_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .ACLK_i(ACLK_i), .ARESETN_i(ARESETN_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
        .resp_resp_o(resp_resp_o), .resp_err_o(resp_err_o), .resp_timeout_o(resp_timeout_o),
        .ARADDR_o(ARADDR_o), .ARVALID_o(ARVALID_o), .ARREADY_i(ARREADY_i),
        .RDATA_i(RDATA_i), .RRESP_i(RRESP_i), .RVALID_i(RVALID_i), .RREADY_o(RREADY_o),
        .AWADDR_o(AWADDR_o), .AWVALID_o(AWVALID_o), .AWREADY_i(AWREADY_i),
        .WDATA_o(WDATA_o), .WSTRB_o(WSTRB_o), .WVALID_o(WVALID_o), .WREADY_i(WREADY_i),
        .BRESP_i(BRESP_i), .BVALID_i(BVALID_i), .BREADY_o(BREADY_o),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    always #5 ACLK_i = ~ACLK_i;

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        ARREADY_i = 1'b0; RVALID_i = 1'b0; RDATA_i = 32'h0; RRESP_i = 2'b00;
        AWREADY_i = 1'b0; WREADY_i = 1'b0; BVALID_i = 1'b0; BRESP_i = 2'b00;
    endtask

    // Driver + slave model: issues one request and plays the slave for it.
    task automatic run_vec(input int idx, input vec_t v);
        int first, a_hi, w_hi, a_cnt, w_cnt, d_cnt;
        bit done, addr_bad, proto_bad, hold_bad;
        logic [31:0] got_rdata;
        logic [1:0]  got_resp;
        logic        got_err, got_to;
        string tag;
        tag = $sformatf("v%0d", idx);
        first = -1; a_hi = 0; w_hi = 0; a_cnt = 0; w_cnt = 0; d_cnt = 0;
        done = 0; addr_bad = 0; proto_bad = 0; hold_bad = 0;
        got_rdata = 32'hx; got_resp = 2'bx; got_err = 1'bx; got_to = 1'bx;
        @(negedge ACLK_i);
        resp_ready_i = 1'b0;
        slave_idle();
        check({tag, "_req_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_write_i = v.wr; req_addr_i = v.addr;
        req_wdata_i = v.wdata; req_wstrb_i = v.wstrb;
        for (int cyc = 1; cyc <= 150 && !done; cyc++) begin
            @(negedge ACLK_i);
            req_valid_i = 1'b0;
            if (v.wr) begin
                if (ARVALID_o || RREADY_o) proto_bad = 1;
                if (AWVALID_o) begin
                    if (AWADDR_o !== v.addr) addr_bad = 1;
                    a_hi++;
                end
                if (WVALID_o) begin
                    if (WDATA_o !== v.wdata || WSTRB_o !== v.wstrb) addr_bad = 1;
                    w_hi++;
                end
                AWREADY_i = AWVALID_o && (a_cnt >= v.a_dly);
                if (AWVALID_o) a_cnt++;
                WREADY_i = WVALID_o && (w_cnt >= v.w_dly);
                if (WVALID_o) w_cnt++;
                BVALID_i = BREADY_o && (d_cnt >= v.d_dly);
                BRESP_i  = BVALID_i ? v.sresp : 2'b00;
                if (BREADY_o) d_cnt++;
            end else begin
                if (AWVALID_o || WVALID_o || BREADY_o) proto_bad = 1;
                if (ARVALID_o) begin
                    if (ARADDR_o !== v.addr) addr_bad = 1;
                    a_hi++;
                end
                ARREADY_i = ARVALID_o && (a_cnt >= v.a_dly);
                if (ARVALID_o) a_cnt++;
                RVALID_i = RREADY_o && (d_cnt >= v.d_dly);
                RDATA_i  = RVALID_i ? v.sdata : 32'h0;
                RRESP_i  = RVALID_i ? v.sresp : 2'b00;
                if (RREADY_o) d_cnt++;
            end
            if (resp_valid_o) begin
                if (first < 0) begin
                    first = cyc;
                    got_rdata = resp_rdata_o; got_resp = resp_resp_o;
                    got_err = resp_err_o; got_to = resp_timeout_o;
                end
                if (resp_rdata_o !== v.exp_rdata || resp_resp_o !== v.exp_resp ||
                    resp_err_o !== v.exp_err || req_ready_o !== 1'b0) hold_bad = 1;
                if (cyc - first >= v.hold) begin
                    resp_ready_i = 1'b1;
                    done = 1;
                end
            end
        end
        check({tag, "_resp_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, first, v.exp_lat);
        check({tag, "_rdata"}, got_rdata, v.exp_rdata);
        check({tag, "_resp"}, 32'(got_resp), 32'(v.exp_resp));
        check({tag, "_err"}, 32'(got_err), 32'(v.exp_err));
        check({tag, "_timeout"}, 32'(got_to), 32'(v.exp_to));
        check({tag, "_addr_valid_cycles"}, a_hi, v.exp_a_hi);
        check({tag, "_wvalid_cycles"}, w_hi, v.exp_w_hi);
        check({tag, "_payload_stable"}, 32'(addr_bad), 32'd0);
        check({tag, "_wrong_channel"}, 32'(proto_bad), 32'd0);
        check({tag, "_resp_held"}, 32'(hold_bad), 32'd0);
    endtask

    initial begin
        bit stale;
        vec_t tv;
        // wr addr wdata wstrb a_dly w_dly d_dly hold sdata sresp lat a_hi w_hi rdata resp err to
        vecs[0] = '{0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 3, 1, 0, 32'hDEAD_BEEF, 2'b00, 0, 0};
        vecs[1] = '{1, 32'h0000_0020, 32'h1234_5678, 4'h5, 2, 0, 0, 0, 32'h0, 2'b00, 5, 3, 1, 32'h0, 2'b00, 0, 0};
        vecs[2] = '{0, 32'h0000_0030, 32'h0, 4'h0, 0, 0, 0, 5, 32'hCAFE_F00D, 2'b11, 3, 1, 0, 32'hCAFE_F00D, 2'b11, 1, 0};
        vecs[3] = '{1, 32'h0000_0044, 32'hA5A5_0F0F, 4'hF, 0, 3, 2, 0, 32'h0, 2'b10, 8, 1, 4, 32'h0, 2'b10, 1, 0};
        vecs[4] = '{0, 32'h0000_0008, 32'h0, 4'h0, 1, 0, 2, 1, 32'h0102_0304, 2'b01, 6, 2, 0, 32'h0102_0304, 2'b01, 0, 0};
        vecs[5] = '{1, 32'hFFFF_FFFC, 32'h8000_0001, 4'h9, 1, 1, 0, 0, 32'h0, 2'b00, 4, 2, 2, 32'h0, 2'b00, 0, 0};
        vecs[6] = '{0, 32'h0000_0ABC, 32'h0, 4'h0, 0, 0, 0, 0, 32'h7654_3210, 2'b00, 3, 1, 0, 32'h7654_3210, 2'b00, 0, 0};

        ARESETN_i = 1'b0;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = 32'h0;
        req_wdata_i = 32'h0; req_wstrb_i = 4'h0; resp_ready_i = 1'b0;
        slave_idle();
        repeat (3) @(negedge ACLK_i);
        check("rst_req_ready", 32'(req_ready_o), 32'd1);
        check("rst_valids", {24'h0, ARVALID_o, RREADY_o, AWVALID_o, WVALID_o, BREADY_o,
                             resp_valid_o, resp_err_o, resp_timeout_o}, 32'h0);
        check("rst_addr_data", ARADDR_o | AWADDR_o | WDATA_o | resp_rdata_o, 32'h0);
        check("rst_strb_resp", {26'h0, WSTRB_o, resp_resp_o}, 32'h0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        ARESETN_i = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset while waiting for read data.
        @(negedge ACLK_i);
        resp_ready_i = 1'b0;
        slave_idle();
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0050;
        @(negedge ACLK_i);
        req_valid_i = 1'b0;
        check("mid_arvalid", 32'(ARVALID_o), 32'd1);
        ARREADY_i = ARVALID_o;
        @(negedge ACLK_i);
        ARREADY_i = 1'b0;
        check("mid_rready", 32'(RREADY_o), 32'd1);
        #2 ARESETN_i = 1'b0;
        #1;
        check("mid_rst_valids", {24'h0, ARVALID_o, RREADY_o, AWVALID_o, WVALID_o, BREADY_o,
                                 resp_valid_o, resp_err_o, resp_timeout_o}, 32'h0);
        check("mid_rst_araddr", ARADDR_o, 32'h0);
        check("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
        @(negedge ACLK_i);
        ARESETN_i = 1'b1;
        RVALID_i = 1'b1; RDATA_i = 32'hBAD0_BAD0;
        stale = 0;
        repeat (3) begin
            @(negedge ACLK_i);
            if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || RREADY_o !== 1'b0) stale = 1;
        end
        check("post_rst_no_stale_resp", 32'(stale), 32'd0);
        slave_idle();
        run_vec(10, vecs[0]);

`ifdef AXI4L_TIMEOUT_EN
        tv = '{0, 32'h0000_0060, 32'h0, 4'h0, 1000, 0, 0, 0, 32'h0, 2'b00, 9, 8, 0, 32'h0, 2'b10, 1, 1};
        run_vec(20, tv);
`else
        tv = vecs[6];
        run_vec(20, tv);
`endif

        @(negedge ACLK_i);
        resp_ready_i = 1'b0;
        check("final_idle", 32'(req_ready_o), 32'd1);
        check("final_no_resp", 32'(resp_valid_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
